fetch_dispatch_ctrl: RTL

- Instruction fetch and dispatch controller for the microcontroller datapath. Fetches a 16-bit instruction word over the shared bus, latches it into the instruction register and increments the PC.
- Presents the word to the opcode-triggered execution FSMs (ALU-immediate, ALU-register, memory) and waits for the selected unit's done pulse before fetching again.
- Sits directly upstream of the execution FSMs. Its ir output drives their fullBitNum input.

---
 rtl/fetch_dispatch_ctrl_pkg.sv | 51 +++++
 rtl/fetch_dispatch_ctrl_if.sv | 34 +++
 rtl/fetch_dispatch_ctrl_opcode_class_decode.sv | 21 ++
 rtl/fetch_dispatch_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fetch_dispatch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch/dispatch controller.
package fetch_dispatch_ctrl_pkg;

    localparam int unsigned IR_W  = 16;
    localparam int unsigned OPC_W = 4;
    localparam int unsigned EX_N  = 3;

    localparam int unsigned EX_ALUI = 0;
    localparam int unsigned EX_ALUR = 1;
    localparam int unsigned EX_MEM  = 2;

    localparam logic [OPC_W-1:0] OP_NOP   = 4'h0;
    localparam logic [OPC_W-1:0] OP_ADDI  = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUBI  = 4'h2;
    localparam logic [OPC_W-1:0] OP_ADD   = 4'h3;
    localparam logic [OPC_W-1:0] OP_SUB   = 4'h4;
    localparam logic [OPC_W-1:0] OP_LOAD  = 4'h5;
    localparam logic [OPC_W-1:0] OP_STORE = 4'h6;
    localparam logic [OPC_W-1:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_F_ADDR  = 3'd1,
        S_F_READ  = 3'd2,
        S_F_LATCH = 3'd3,
        S_F_INC   = 3'd4,
        S_DECODE  = 3'd5,
        S_EXEC    = 3'd6,
        S_HALT    = 3'd7
    } state_e;

    typedef struct packed {
        logic [EX_N-1:0] exec_sel;
        logic            is_nop;
        logic            is_halt;
        logic            is_illegal;
    } op_class_t;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic mem_read;
        logic ir_in;
        logic pc_inc;
    } strobe_t;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [IR_W-1:0] word);
        return word[IR_W-1 -: OPC_W];
    endfunction

endpackage

// File: rtl/fetch_dispatch_ctrl_if.sv
// Bus/handshake bundle between the fetch controller and its datapath and executors.
interface fetch_dispatch_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    import fetch_dispatch_ctrl_pkg::*;

    logic                 run;
    logic [IR_W-1:0]      bus_in;
    logic [EX_N-1:0]      exec_done;
    logic                 PC_out;
    logic                 MAR_in;
    logic                 MEM_read;
    logic                 IR_in;
    logic                 PC_inc;
    logic [IR_W-1:0]      ir;
    logic [EX_N-1:0]      exec_sel;
    logic                 halted;
    logic                 illegal;
    logic                 timeout_err;
    logic [CNT_W-1:0]     instr_count;

    modport master (
        input  run, bus_in, exec_done,
        output PC_out, MAR_in, MEM_read, IR_in, PC_inc,
        output ir, exec_sel, halted, illegal, timeout_err, instr_count
    );

    modport slave (
        output run, bus_in, exec_done,
        input  PC_out, MAR_in, MEM_read, IR_in, PC_inc,
        input  ir, exec_sel, halted, illegal, timeout_err, instr_count
    );

endinterface

// File: rtl/fetch_dispatch_ctrl_opcode_class_decode.sv
// Opcode classifier: executor select plus NOP/HALT/illegal flags.
module fetch_dispatch_ctrl_opcode_class_decode
    import fetch_dispatch_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output op_class_t        cls_c
);

    always_comb begin
        cls_c = '0;
        case (opcode)
            OP_NOP:             cls_c.is_nop = 1'b1;
            OP_ADDI, OP_SUBI:   cls_c.exec_sel[EX_ALUI] = 1'b1;
            OP_ADD, OP_SUB:     cls_c.exec_sel[EX_ALUR] = 1'b1;
            OP_LOAD, OP_STORE:  cls_c.exec_sel[EX_MEM]  = 1'b1;
            OP_HALT:            cls_c.is_halt = 1'b1;
            default:            cls_c.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_dispatch_ctrl.sv
// Fetch/decode/dispatch sequencer: fetches one word, hands it to an executor,
// and waits for that executor's done (or a timeout) before fetching again.
module fetch_dispatch_ctrl
    import fetch_dispatch_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_dispatch_ctrl_if.master bus
);

    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e            state_q;
    state_e            state_d;
    logic [IR_W-1:0]   ir_q;
    logic [WAIT_W-1:0] wait_q;
    logic [CNT_W-1:0]  count_q;
    logic              timeout_q;

    strobe_t           strb_q;
    strobe_t           strb_d;
    logic [IR_W-1:0]   ir_out_q;
    logic [IR_W-1:0]   ir_out_d;
    logic [EX_N-1:0]   sel_q;
    logic [EX_N-1:0]   sel_d;
    logic              halted_q;
    logic              halted_d;
    logic              illegal_q;
    logic              illegal_d;

    op_class_t         cls;
    logic              done_hit;
    logic              wait_last;

    fetch_dispatch_ctrl_opcode_class_decode u_class (
        .opcode (opcode_of(ir_q)),
        .cls_c  (cls)
    );

    // Only the bit of the selected executor can retire; sel_q is zero outside EXEC.
    assign done_hit  = |(bus.exec_done & sel_q);
    assign wait_last = (wait_q == WAIT_W'(TIMEOUT - 1));

    // State register; outputs are registered from the next-state decode so they track the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            strb_q    <= '0;
            ir_out_q  <= '0;
            sel_q     <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            strb_q    <= strb_d;
            ir_out_q  <= ir_out_d;
            sel_q     <= sel_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.run) state_d = S_F_ADDR;
            S_F_ADDR:  state_d = S_F_READ;
            S_F_READ:  state_d = S_F_LATCH;
            S_F_LATCH: state_d = S_F_INC;
            S_F_INC:   state_d = S_DECODE;
            S_DECODE: begin
                if (cls.is_halt)                       state_d = S_HALT;
                else if (cls.is_nop || cls.is_illegal) state_d = S_IDLE;
                else                                   state_d = S_EXEC;
            end
            S_EXEC:    if (done_hit || wait_last) state_d = S_IDLE;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_IDLE;
        endcase
    end

    // Moore output decode of the upcoming state; ir_q is already stable whenever DECODE/EXEC is entered.
    always_comb begin
        strb_d    = '0;
        ir_out_d  = '0;
        sel_d     = '0;
        halted_d  = 1'b0;
        illegal_d = 1'b0;
        case (state_d)
            S_F_ADDR: begin
                strb_d.pc_out = 1'b1;
                strb_d.mar_in = 1'b1;
            end
            S_F_READ:  strb_d.mem_read = 1'b1;
            S_F_LATCH: begin
                strb_d.mem_read = 1'b1;
                strb_d.ir_in    = 1'b1;
            end
            S_F_INC:   strb_d.pc_inc = 1'b1;
            S_DECODE: begin
                ir_out_d  = ir_q;
                illegal_d = cls.is_illegal;
            end
            S_EXEC: begin
                ir_out_d = ir_q;
                sel_d    = cls.exec_sel;
            end
            S_HALT:    halted_d = 1'b1;
            default:   ;
        endcase
    end

    // Instruction register, EXEC wait counter, retire counter and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q      <= '0;
            wait_q    <= '0;
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == S_F_LATCH) ir_q <= bus.bus_in;

            if (state_q == S_DECODE)    wait_q <= '0;
            else if (state_q == S_EXEC) wait_q <= wait_q + WAIT_W'(1);

            if ((state_q == S_DECODE && cls.is_nop) || (state_q == S_EXEC && done_hit))
                count_q <= count_q + CNT_W'(1);

            if (state_q == S_EXEC && !done_hit && wait_last)
                timeout_q <= 1'b1;
        end
    end

    assign bus.PC_out      = strb_q.pc_out;
    assign bus.MAR_in      = strb_q.mar_in;
    assign bus.MEM_read    = strb_q.mem_read;
    assign bus.IR_in       = strb_q.ir_in;
    assign bus.PC_inc      = strb_q.pc_inc;
    assign bus.ir          = ir_out_q;
    assign bus.exec_sel    = sel_q;
    assign bus.halted      = halted_q;
    assign bus.illegal     = illegal_q;
    assign bus.timeout_err = timeout_q;
    assign bus.instr_count = count_q;

endmodule
